// File: rtl/fht_loader_pkg.sv
// Shared parameters and state encoding for the FHT input loader and its companions.
package fht_loader_pkg;

   localparam int D_BIT     = 16;
   localparam int A_BIT     = 8;
   localparam int BANK_SIZE = 1 << A_BIT;
   localparam int N         = 4 * BANK_SIZE;
   localparam int IDX_BIT   = A_BIT + 2;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/fht_bitrev.sv
// Combinational bit reversal of an index; shared by the loader and the output unloader.
module fht_bitrev #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
         assign dout[gi] = din[WIDTH-1-gi];
      end
   endgenerate

endmodule

// File: rtl/fht_loader.sv
// Serial sample loader: writes each accepted sample to its bit-reversed bank/address,
// strobes the core once per frame and blocks input until the core reports completion.
module fht_loader #(
   parameter int D_BIT = fht_loader_pkg::D_BIT,
   parameter int A_BIT = fht_loader_pkg::A_BIT
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iVALID,
   input  logic [D_BIT-1:0] iDATA,
   output logic             oREADY,
   input  logic             iFHT_RDY,
   output logic [3:0]       oWE,
   output logic [D_BIT-1:0] oDATA_0,
   output logic [D_BIT-1:0] oDATA_1,
   output logic [D_BIT-1:0] oDATA_2,
   output logic [D_BIT-1:0] oDATA_3,
   output logic [A_BIT-1:0] oADDR_WR_0,
   output logic [A_BIT-1:0] oADDR_WR_1,
   output logic [A_BIT-1:0] oADDR_WR_2,
   output logic [A_BIT-1:0] oADDR_WR_3,
   output logic             oSTART,
   output logic             oBUSY,
   output logic [A_BIT+1:0] oCNT
);

   import fht_loader_pkg::*;

   localparam int IW   = A_BIT + 2;
   localparam int NPTS = 4 << A_BIT;

   state_t           state_reg, state_next;
   logic             ready_reg;
   logic [IW-1:0]    cnt_reg;
   logic [3:0]       we_reg;
   logic [D_BIT-1:0] data_reg;
   logic [A_BIT-1:0] addr_reg;
   logic [IW-1:0]    rev_idx;
   logic             transfer;
   logic             last_xfer;

   fht_bitrev #(.WIDTH(IW)) u_bitrev (
      .din  (cnt_reg),
      .dout (rev_idx)
   );

   // ready_reg is only ever set while in LOAD, so it alone qualifies a transfer
   assign transfer  = iVALID && ready_reg;
   assign last_xfer = transfer && (cnt_reg == IW'(NPTS - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LOAD:    if (last_xfer) state_next = START;
         START:   state_next = WAIT;
         WAIT:    if (iFHT_RDY) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_reg <= LOAD;
         ready_reg <= 1'b0;
         cnt_reg   <= '0;
         we_reg    <= '0;
         data_reg  <= '0;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         // Registered so it stays low through reset and rises on the first edge after it
         ready_reg <= (state_next == LOAD);
         if (transfer) begin
            cnt_reg  <= cnt_reg + 1'b1;
            we_reg   <= 4'b0001 << rev_idx[1:0];
            data_reg <= iDATA;
            addr_reg <= rev_idx[IW-1:2];
         end else begin
            we_reg <= '0;
         end
         if (state_reg == WAIT && iFHT_RDY) cnt_reg <= '0;
      end
   end

   assign oREADY     = ready_reg;
   assign oWE        = we_reg;
   assign oDATA_0    = data_reg;
   assign oDATA_1    = data_reg;
   assign oDATA_2    = data_reg;
   assign oDATA_3    = data_reg;
   assign oADDR_WR_0 = addr_reg;
   assign oADDR_WR_1 = addr_reg;
   assign oADDR_WR_2 = addr_reg;
   assign oADDR_WR_3 = addr_reg;
   assign oSTART     = (state_reg == START);
   assign oBUSY      = (state_reg == START) || (state_reg == WAIT);
   assign oCNT       = cnt_reg;

endmodule

// File: tb/tb_fht_loader.sv
// Randomised bench for fht_loader (N=16) with a frame-level reference model and literal anchors.
module tb_fht_loader;

   localparam int D_BIT = 16;
   localparam int A_BIT = 2;
   localparam int NPTS  = 4 << A_BIT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             iVALID;
   logic [D_BIT-1:0] iDATA;
   logic             iFHT_RDY;
   logic             oREADY, oSTART, oBUSY;
   logic [3:0]       oWE;
   logic [D_BIT-1:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
   logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
   logic [A_BIT+1:0] oCNT;

   fht_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
      .iCLK       (clk),
      .iRESET     (rst_n),
      .iVALID     (iVALID),
      .iDATA      (iDATA),
      .oREADY     (oREADY),
      .iFHT_RDY   (iFHT_RDY),
      .oWE        (oWE),
      .oDATA_0    (oDATA_0),
      .oDATA_1    (oDATA_1),
      .oDATA_2    (oDATA_2),
      .oDATA_3    (oDATA_3),
      .oADDR_WR_0 (oADDR_WR_0),
      .oADDR_WR_1 (oADDR_WR_1),
      .oADDR_WR_2 (oADDR_WR_2),
      .oADDR_WR_3 (oADDR_WR_3),
      .oSTART     (oSTART),
      .oBUSY      (oBUSY),
      .oCNT       (oCNT)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int st_cnt = 0;

   // Reference model state: frame phase flags plus expected write-cycle outputs
   bit               m_ready, m_start, m_wait;
   int               m_cnt;
   logic [3:0]       e_we;
   logic [D_BIT-1:0] e_data;
   int               e_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rev4(input int n);
      int r = 0;
      for (int i = 0; i < A_BIT + 2; i++)
         if (((n >> i) & 1) != 0) r |= 1 << (A_BIT + 1 - i);
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_ready = 0; m_start = 0; m_wait = 0; m_cnt = 0;
            e_we = 0; e_data = 0; e_addr = 0;
         end else begin
            if (iVALID && m_ready) begin
               e_we   = 4'(1 << (rev4(m_cnt) % 4));
               e_addr = rev4(m_cnt) / 4;
               e_data = iDATA;
               m_cnt++;
            end else begin
               e_we = 0;
            end
            if (m_start) begin
               m_start = 0; m_wait = 1;
            end else if (m_wait && iFHT_RDY) begin
               m_wait = 0; m_cnt = 0;
            end else if (!m_wait && m_cnt == NPTS) begin
               m_start = 1;
            end
            m_ready = !m_start && !m_wait;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("ready", 32'(oREADY), 32'(m_ready));
         chk("we", 32'(oWE), 32'(e_we));
         chk("start", 32'(oSTART), 32'(m_start));
         chk("busy", 32'(oBUSY), 32'(m_start || m_wait));
         chk("cnt", 32'(oCNT), 32'(m_cnt % NPTS));
         if (e_we != 0) begin
            chk("data0", 32'(oDATA_0), 32'(e_data));
            chk("data1", 32'(oDATA_1), 32'(e_data));
            chk("data2", 32'(oDATA_2), 32'(e_data));
            chk("data3", 32'(oDATA_3), 32'(e_data));
            chk("addr0", 32'(oADDR_WR_0), 32'(e_addr));
            chk("addr1", 32'(oADDR_WR_1), 32'(e_addr));
            chk("addr2", 32'(oADDR_WR_2), 32'(e_addr));
            chk("addr3", 32'(oADDR_WR_3), 32'(e_addr));
         end
         if (oWE != 0) wr_cnt++;
         if (oSTART) st_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [D_BIT-1:0] d, input bit gaps);
      bit rdy;
      bit ok = 0;
      if (gaps)
         for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
            iVALID = 0;
            step();
         end
      iVALID = 1;
      iDATA  = d;
      for (int t = 0; t < 300; t++) begin
         rdy = oREADY;
         step();
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      $display("xfer data=%04h we=%b addr=%0d cnt=%0d", d, oWE, oADDR_WR_0, oCNT);
      iVALID = 0;
   endtask

   task automatic pulse_rdy();
      iFHT_RDY = 1;
      step();
      iFHT_RDY = 0;
   endtask

   // Literal anchors for the gapless 0..15 frame: {n, oWE, address}
   int lit_tab [4][3] = '{'{1, 1, 2}, '{2, 1, 1}, '{3, 1, 3}, '{5, 4, 2}};

   initial begin
      rst_n = 0; iVALID = 0; iDATA = 0; iFHT_RDY = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      step();

      // Frame 1: gapless ramp
      wr_cnt = 0; st_cnt = 0;
      for (int n = 0; n < NPTS; n++) begin
         send(D_BIT'(n), 0);
         for (int k = 0; k < 4; k++)
            if (lit_tab[k][0] == n) begin
               chk("lit_we", 32'(oWE), 32'(lit_tab[k][1]));
               chk("lit_addr", 32'(oADDR_WR_0), 32'(lit_tab[k][2]));
            end
      end
      chk("lit_start_after_last", 32'(oSTART), 32'd1);
      repeat (4) step();
      chk("f1_writes", 32'(wr_cnt), 32'd16);
      chk("f1_starts", 32'(st_cnt), 32'd1);
      pulse_rdy();

      // Frame 2: random gaps, extreme samples, stray core-ready pulses
      wr_cnt = 0; st_cnt = 0;
      for (int n = 0; n < NPTS; n++) begin
         logic [D_BIT-1:0] d;
         d = (n == 0) ? 16'h8000 : (n == 1) ? 16'h7fff : D_BIT'($urandom);
         send(d, 1);
         if (n < 2) begin
            chk("lit_data0", 32'(oDATA_0), 32'(d));
            chk("lit_data3", 32'(oDATA_3), 32'(d));
         end
         if (n == 6) pulse_rdy();
      end
      iVALID = 1; iDATA = 16'h1234;
      pulse_rdy();
      repeat (5) step();
      chk("f2_writes", 32'(wr_cnt), 32'd16);
      chk("f2_starts", 32'(st_cnt), 32'd1);
      chk("lit_wait_ready", 32'(oREADY), 32'd0);
      pulse_rdy();
      chk("lit_ready_after_rdy", 32'(oREADY), 32'd1);
      step();
      iVALID = 0;
      chk("lit_n0_we", 32'(oWE), 32'd1);
      chk("lit_n0_addr", 32'(oADDR_WR_0), 32'd0);
      chk("lit_n0_data", 32'(oDATA_1), 32'h1234);

      // Frame 3: abort by reset after nine samples
      for (int n = 1; n < 9; n++) send(D_BIT'($urandom), 1);
      #1 rst_n = 0;
      #1;
      chk("rst_we", 32'(oWE), 32'd0);
      chk("rst_cnt", 32'(oCNT), 32'd0);
      chk("rst_ready", 32'(oREADY), 32'd0);
      chk("rst_data", 32'(oDATA_2), 32'd0);
      chk("rst_addr", 32'(oADDR_WR_1), 32'd0);
      chk("rst_busy", 32'(oBUSY), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      step();

      // Frame 4: complete random frame after reset
      wr_cnt = 0; st_cnt = 0;
      for (int n = 0; n < NPTS; n++) send(D_BIT'($urandom), 1);
      repeat (3) step();
      chk("f4_writes", 32'(wr_cnt), 32'd16);
      chk("f4_starts", 32'(st_cnt), 32'd1);
      pulse_rdy();
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fht_loader.md
# fht_loader

Input-side stage ahead of the FHT core. It accepts a serial stream of signed samples through a valid/ready handshake and writes each sample into the four-bank input RAM at its bit-reversed position. After the last point of a frame it issues the one-cycle start strobe, then holds off new input until the core reports completion. It drives the core's write-enable, data and write-address load ports and consumes the core's ready signal.

## Interface
- D_BIT, 16: sample width (signed, two's complement).
- A_BIT, 8: bank address width; frame length N = 4·2^A_BIT points; index width A_BIT+2.

- iCLK  in  1  single clock, rising edge.
- iRESET  in  1  asynchronous, active-low reset.
- iVALID  in  1  upstream sample valid.
- iDATA  in  D_BIT  upstream sample (signed).
- oREADY  out  1  loader can accept a sample this cycle.
- iFHT_RDY  in  1  one-cycle pulse from the core when a transform is complete.
- oWE  out  4  one-hot bank write enable, core load port.
- oDATA_0..oDATA_3  out  D_BIT each  write data; all four carry the same registered sample.
- oADDR_WR_0..oADDR_WR_3  out  A_BIT each  write address; all four carry the same value.
- oSTART  out  1  one-cycle start strobe to the core.
- oBUSY  out  1  high from oSTART until iFHT_RDY is accepted.
- oCNT  out  A_BIT+2  number of samples accepted in the current frame.

## Operation
- Reset values: oREADY=0, oWE=0, oDATA_*=0, oADDR_WR_*=0, oSTART=0, oBUSY=0, oCNT=0, state LOAD (oREADY rises the first cycle after reset deasserts).
- States:
  - LOAD: oREADY=1. A transfer occurs when iVALID && oREADY at a rising edge; the sample index is n=oCNT. The Nth transfer (n=N-1) moves to START.
  - START: oREADY=0; oSTART=1 for exactly this one cycle; next state WAIT.
  - WAIT: oREADY=0, oBUSY=1. iFHT_RDY=1 returns the block to LOAD with oCNT=0.
- Address mapping for index n: r = bit-reverse of n over A_BIT+2 bits; bank = r[1:0] (oWE = 1<<bank); address = r[A_BIT+1:2].
- Counter: increments on each transfer; cleared on entry to LOAD from WAIT. It never wraps inside a frame.
- iVALID while oREADY=0: ignored; no write occurs and the sample must be held by upstream.
- iFHT_RDY outside WAIT: ignored, including when it coincides with oSTART.
- iDATA: passed unmodified, no scaling.
- Reset mid-frame: partial frame discarded, oCNT=0, no oSTART. RAM contents are left as-is and are overwritten by the next frame.

## Timing
- Write latency: a transfer at edge k gives oWE/oDATA/oADDR valid in cycle k→k+1 only. oWE is 0 in every cycle without a preceding transfer.
- Back-to-back transfers allowed: peak throughput is 1 sample/clock.
- Last transfer at edge k: the last write is in cycle k→k+1, which is also START (oSTART=1, oREADY=0). WAIT begins at k+1.
- iFHT_RDY sampled at edge j in WAIT: oREADY=1 from j; first new-frame transfer possible at edge j+1.
- Minimum frame period: N + 1 + core latency + 1 cycles.

## Structure
- Shared package/defines: D_BIT, A_BIT, BANK_SIZE, N, index width, state encoding (LOAD, START, WAIT).
- Sub-module fht_bitrev (parameter WIDTH): combinational bit-reversal. Reusable by the output unloader.
- Everything else is in one module: FSM, counter, output registers.

## Test plan
- A_BIT=2 (N=16), feed 0..15 continuously -> bank/address pairs: n=1→bank0/addr2, n=2→bank0/addr1, n=3→bank0/addr3, n=5→bank2/addr2; exactly 16 single-bit oWE cycles; oSTART one cycle after the 16th transfer.
- Random iVALID gaps (about 50%) -> identical write sequence to the gapless case; oCNT matches the transfer count at every edge.
- iVALID held high through START/WAIT -> no writes and oREADY=0 until the cycle after iFHT_RDY. The next frame's n=0 write goes to bank0/addr0.
- iFHT_RDY pulsed during LOAD at n=7 -> no effect; frame completes normally.
- iRESET low at n=9 -> all outputs 0 asynchronously. After release, 16 new samples produce a full frame and one oSTART.
- iDATA = -32768 and 32767 (D_BIT=16) -> appear bit-exact on all four oDATA_* in the write cycle.
